period_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous square wave in master-clock cycles. It complements the stopwatch clock divider: the divider turns the 100 MHz clock into slow waves, and this block turns a slow wave back into a cycle count. It is used to self-check divider outputs (clk_2Hz, clk_5Hz, clk_10Hz, clk_500Hz) on hardware and to time external inputs such as buttons.

---
 rtl/period_meter.sv | 101 ++++++++++
 tb/tb_period_meter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Measures the period and high time of a slow asynchronous square wave in
// master-clock cycles; each completed period is reported with a one-cycle pulse.
module period_meter #(
    parameter int unsigned CNT_WIDTH = 28,
    parameter int unsigned TIMEOUT   = 200000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] meas_period,
    output logic [CNT_WIDTH-1:0] meas_high,
    output logic                 meas_valid,
    output logic                 timeout,
    output logic                 active
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t               state;
    logic                 s1;
    logic                 s2;
    logic                 s3;
    logic [1:0]           fill;
    logic                 rise;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] hcnt;

    // Until the synchronizer holds real samples, s3 follows s1 so that s3
    // equals s2 once s2 first carries sig_in: a level already high at reset
    // release is not mistaken for a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b1;
            fill <= 2'b00;
        end else begin
            s1   <= sig_in;
            s2   <= s1;
            s3   <= fill[1] ? s2 : s1;
            fill <= {fill[0], 1'b1};
        end
    end

    assign rise = s2 & ~s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            hcnt        <= '0;
            meas_period <= '0;
            meas_high   <= '0;
            meas_valid  <= 1'b0;
            timeout     <= 1'b0;
            active      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt    <= ONE;
                        hcnt   <= ONE;
                        state  <= MEASURE;
                        active <= 1'b1;
                    end
                end
                MEASURE: begin
                    // A rise wins over the timeout check, so a period of
                    // exactly TIMEOUT is still reported.
                    if (rise) begin
                        meas_period <= cnt;
                        meas_high   <= hcnt;
                        meas_valid  <= 1'b1;
                        timeout     <= 1'b0;
                        cnt         <= ONE;
                        hcnt        <= ONE;
                    end else if (cnt == TIMEOUT_CNT) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                        active  <= 1'b0;
                    end else begin
                        cnt  <= cnt + ONE;
                        hcnt <= hcnt + CNT_WIDTH'(s2);
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: directed and random square waves; a
// sample-level model predicts every reported period, high time and pulse cycle.
`timescale 1ns/1ps
module tb_period_meter;

    localparam int CW = 28;
    localparam int TO = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sig_in = 1'b0;
    logic [CW-1:0] meas_period;
    logic [CW-1:0] meas_high;
    logic          meas_valid;
    logic          timeout;
    logic          active;

    period_meter #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .meas_period(meas_period),
        .meas_high  (meas_high),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .active     (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint period;
        longint high;
        longint edge_no;
    } exp_t;

    exp_t   sb[$];
    exp_t   got;
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;

    // model state: samples taken at each clock edge after reset release
    bit     base_set = 1'b0;
    bit     prev = 1'b0;
    bit     armed = 1'b0;
    longint last_rise = 0;
    longint highs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A period is the distance between two 0->1 transitions of the sampled
    // input; it is reported two edges after the closing rise if it is no longer
    // than TO, otherwise the meter has given up and that rise only re-arms.
    task automatic model_step(input bit v);
        longint k;
        exp_t   e;
        k = cyc + 1;
        if (!base_set) begin
            base_set = 1'b1;
            prev     = v;
        end else begin
            if (v && !prev) begin
                if (armed && (k - last_rise) <= TO) begin
                    e.period  = k - last_rise;
                    e.high    = highs;
                    e.edge_no = k + 2;
                    sb.push_back(e);
                end
                armed     = 1'b1;
                last_rise = k;
                highs     = 0;
            end
            prev = v;
        end
        if (v) highs++;
    endtask

    task automatic drive(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sig_in = v;
            model_step(v);
        end
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_period", meas_period, 0);
        chk("rst_high", meas_high, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_active", active, 0);
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        base_set = 1'b0;
        armed    = 1'b0;
        model_step(sig_in);
    endtask

    always @(negedge clk) begin
        if (!rst && meas_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: meas_period %0d meas_high %0d with nothing expected (cycle %0d)",
                         meas_period, meas_high, cyc);
            end else begin
                got = sb.pop_front();
                chk("period", meas_period, got.period);
                chk("high", meas_high, got.high);
                chk("valid_cycle", cyc, got.edge_no);
                chk("timeout_at_valid", timeout, 0);
            end
        end
    end

    initial begin
        int hi;
        int lo;

        do_reset();

        // steady wave: period 100, high 30, five rises -> four reports
        drive(1'b0, 20);
        wave(30, 70, 2);
        chk("active_measuring", active, 1);
        wave(30, 70, 3);
        drive(1'b0, 1100);
        chk("timeout_after_steady", timeout, 1);
        chk("active_after_timeout", active, 0);

        // minimum resolvable wave
        wave(2, 2, 20);
        drive(1'b0, 1100);

        // boundary: exactly TO apart is valid, then a gap beyond TO times out
        wave(2, 998, 1);
        drive(1'b1, 2);
        drive(1'b0, 1099);
        chk("timeout_boundary", timeout, 1);
        chk("active_boundary", active, 0);
        chk("period_held_on_timeout", meas_period, TO);
        wave(2, 58, 1);
        wave(2, 30, 1);
        chk("timeout_cleared", timeout, 0);
        drive(1'b0, 1100);

        // input high across reset release gives no edge
        sig_in = 1'b1;
        do_reset();
        drive(1'b1, 19);
        drive(1'b0, 20);
        chk("no_arm_while_high", active, 0);
        chk("no_timeout_while_high", timeout, 0);
        wave(25, 25, 3);
        drive(1'b0, 1100);

        // reset in the middle of a period-200 measurement
        wave(100, 100, 3);
        drive(1'b1, 50);
        do_reset();
        drive(1'b1, 50);
        drive(1'b0, 100);
        wave(100, 100, 3);
        drive(1'b0, 1100);

        // random waves, some gaps straddling the timeout
        for (int i = 0; i < 40; i++) begin
            hi = int'($urandom_range(60, 2));
            lo = ($urandom_range(7, 0) == 0) ? int'($urandom_range(1050, 950))
                                              : int'($urandom_range(60, 2));
            wave(hi, lo, 1);
        end
        drive(1'b0, 1100);

        drive(1'b0, 20);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
